// File: rtl/decode_length_ctrl.sv
// decode_length_ctrl: walks prefixes, opcode, ModRM/SIB/disp and immediate of one x86 instruction and emits its length
// Optional: define DECODE_LEN_PERF_EN to add handshake and stall performance counters.
module decode_length_ctrl #(
    parameter int MAX_PREFIX = 4,
    parameter int MAX_LEN    = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         win_valid,
    output logic         win_ready,
    input  logic [127:0] win_data,
    output logic [7:0]   map_op0,
    output logic [7:0]   map_op1,
    input  logic         map_opsize,
    input  logic         map_modrm,
    input  logic         map_imm1,
    input  logic         map_imm0,
    input  logic         map_f16,
    output logic         ins_valid,
    input  logic         ins_ready,
    output logic [3:0]   ins_len,
    output logic [2:0]   ins_prefix_cnt,
    output logic         ins_opsize_pfx,
    output logic         ins_two_byte,
    output logic         ins_opsize,
    output logic [3:0]   ins_modrm_pos,
    output logic [3:0]   ins_imm_pos,
    output logic [2:0]   ins_imm_len,
    output logic         ins_fault
`ifdef DECODE_LEN_PERF_EN
    ,
    output logic [31:0]  perf_ins_cnt,
    output logic [31:0]  perf_stall_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, PFX, OPC, MRM, LEN, OUT} state_t;

    function automatic logic [7:0] byte_at(input logic [127:0] w, input logic [4:0] i);
        return i[4] ? 8'h00 : w[{i[3:0], 3'b000} +: 8];
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return b inside {8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65};
    endfunction

    state_t       state_q, state_d;
    logic [127:0] win_q, win_d;
    logic [3:0]   ptr_q, ptr_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         opsize_pfx_q, opsize_pfx_d;
    logic         two_byte_q, two_byte_d;
    logic         opsize_q, opsize_d;
    logic         modrm_q, modrm_d;
    logic         sib_q, sib_d;
    logic [2:0]   disp_q, disp_d;
    logic [2:0]   imm_len_q, imm_len_d;
    logic [3:0]   modrm_pos_q, modrm_pos_d;
    logic [3:0]   len_q, len_d;
    logic [3:0]   imm_pos_q, imm_pos_d;
    logic         fault_q, fault_d;

    logic [7:0] cur_b, nxt_b;
    logic       is_0f;
    logic [4:0] mrm_idx, sib_idx;
    logic [1:0] mrm_mod;
    logic [2:0] mrm_rm, sib_base;
    logic       has_sib;
    logic [2:0] imm_sz;
    logic [4:0] raw_len, eff_len, imm_diff;
    logic       over;

    assign cur_b    = byte_at(win_q, {1'b0, ptr_q});
    assign nxt_b    = byte_at(win_q, {1'b0, ptr_q} + 5'd1);
    assign is_0f    = cur_b == 8'h0F;
    assign mrm_idx  = {1'b0, modrm_pos_q};
    assign sib_idx  = mrm_idx + 5'd1;
    assign mrm_mod  = mrm_idx[4] ? 2'b00 : win_q[{mrm_idx[3:0], 3'd6} +: 2];
    assign mrm_rm   = mrm_idx[4] ? 3'b000 : win_q[{mrm_idx[3:0], 3'd0} +: 3];
    assign sib_base = sib_idx[4] ? 3'b000 : win_q[{sib_idx[3:0], 3'd0} +: 3];
    assign has_sib  = mrm_rm == 3'b100 && mrm_mod != 2'b11;
    assign imm_sz   = map_f16 ? 3'd2 :
                      {map_imm1, map_imm0} == 2'b00 ? 3'd0 :
                      {map_imm1, map_imm0} == 2'b01 ? 3'd1 :
                      {map_imm1, map_imm0} == 2'b10 ? 3'd2 :
                      opsize_pfx_q ? 3'd2 : 3'd4;
    assign raw_len  = {2'b00, cnt_q} + (two_byte_q ? 5'd2 : 5'd1) + {4'b0, modrm_q} +
                      {4'b0, sib_q} + {2'b00, disp_q} + {2'b00, imm_len_q};
    assign eff_len  = fault_q ? {1'b0, ptr_q} : raw_len;
    assign over     = eff_len > 5'(MAX_LEN);
    assign imm_diff = eff_len - {2'b00, imm_len_q};

    // next-state and field updates for the length walk
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        opsize_pfx_d = opsize_pfx_q;
        two_byte_d   = two_byte_q;
        opsize_d     = opsize_q;
        modrm_d      = modrm_q;
        sib_d        = sib_q;
        disp_d       = disp_q;
        imm_len_d    = imm_len_q;
        modrm_pos_d  = modrm_pos_q;
        len_d        = len_q;
        imm_pos_d    = imm_pos_q;
        fault_d      = fault_q;
        map_op0      = 8'h00;
        map_op1      = 8'h00;
        case (state_q)
            IDLE: if (win_valid) begin
                state_d      = PFX;
                win_d        = win_data;
                ptr_d        = '0;
                cnt_d        = '0;
                opsize_pfx_d = 1'b0;
                two_byte_d   = 1'b0;
                opsize_d     = 1'b0;
                modrm_d      = 1'b0;
                sib_d        = 1'b0;
                disp_d       = '0;
                imm_len_d    = '0;
                modrm_pos_d  = '0;
                len_d        = '0;
                imm_pos_d    = '0;
                fault_d      = 1'b0;
            end
            PFX: if (!is_prefix(cur_b)) begin
                state_d = OPC;
            end else if (cnt_q == 3'(MAX_PREFIX)) begin
                fault_d = 1'b1;
                state_d = LEN;
            end else begin
                cnt_d        = cnt_q + 3'd1;
                ptr_d        = ptr_q + 4'd1;
                opsize_pfx_d = opsize_pfx_q | (cur_b == 8'h66);
            end
            OPC: begin
                map_op0     = cur_b;
                map_op1     = nxt_b;
                two_byte_d  = is_0f;
                opsize_d    = map_opsize;
                modrm_d     = map_modrm;
                imm_len_d   = imm_sz;
                modrm_pos_d = map_modrm ? ptr_q + (is_0f ? 4'd2 : 4'd1) : 4'd0;
                state_d     = map_modrm ? MRM : LEN;
            end
            MRM: begin
                sib_d   = has_sib;
                disp_d  = mrm_mod == 2'b01 ? 3'd1 :
                          mrm_mod == 2'b10 ? 3'd4 :
                          mrm_mod == 2'b00 && mrm_rm == 3'b101 ? 3'd4 :
                          mrm_mod == 2'b00 && has_sib && sib_base == 3'b101 ? 3'd4 : 3'd0;
                state_d = LEN;
            end
            LEN: begin
                len_d     = over ? 4'(MAX_LEN) : eff_len[3:0];
                fault_d   = fault_q | over;
                imm_pos_d = imm_diff[4] ? 4'hF : imm_diff[3:0];
                state_d   = OUT;
            end
            OUT: if (ins_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and descriptor registers; reset discards any latched window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            win_q        <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            opsize_pfx_q <= 1'b0;
            two_byte_q   <= 1'b0;
            opsize_q     <= 1'b0;
            modrm_q      <= 1'b0;
            sib_q        <= 1'b0;
            disp_q       <= '0;
            imm_len_q    <= '0;
            modrm_pos_q  <= '0;
            len_q        <= '0;
            imm_pos_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            opsize_pfx_q <= opsize_pfx_d;
            two_byte_q   <= two_byte_d;
            opsize_q     <= opsize_d;
            modrm_q      <= modrm_d;
            sib_q        <= sib_d;
            disp_q       <= disp_d;
            imm_len_q    <= imm_len_d;
            modrm_pos_q  <= modrm_pos_d;
            len_q        <= len_d;
            imm_pos_q    <= imm_pos_d;
            fault_q      <= fault_d;
        end
    end

    assign win_ready      = state_q == IDLE && !reset;
    assign ins_valid      = state_q == OUT;
    assign ins_len        = len_q;
    assign ins_prefix_cnt = cnt_q;
    assign ins_opsize_pfx = opsize_pfx_q;
    assign ins_two_byte   = two_byte_q;
    assign ins_opsize     = opsize_q;
    assign ins_modrm_pos  = modrm_pos_q;
    assign ins_imm_pos    = imm_pos_q;
    assign ins_imm_len    = imm_len_q;
    assign ins_fault      = fault_q;

`ifdef DECODE_LEN_PERF_EN
    logic [31:0] perf_ins_cnt_q, perf_ins_cnt_d, perf_stall_cnt_q, perf_stall_cnt_d;

    // count descriptor handshakes and cycles stalled waiting for decode
    always_comb begin
        perf_ins_cnt_d   = perf_ins_cnt_q + ((state_q == OUT && ins_ready) ? 32'd1 : 32'd0);
        perf_stall_cnt_d = perf_stall_cnt_q + ((state_q == OUT && !ins_ready) ? 32'd1 : 32'd0);
    end

    // performance counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ins_cnt_q   <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_ins_cnt_q   <= perf_ins_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_ins_cnt   = perf_ins_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif
endmodule

// File: doc/decode_length_ctrl.md
Name: decode_length_ctrl

Overview:
Sequences the opcode size map for one x86 instruction at a time. Latches a 16-byte fetch window and walks its prefixes. Drives the opcode bytes into the size map and samples its flags. Resolves ModRM/SIB/displacement and immediate sizes, then emits instruction length and field positions to the decode stage over a valid/ready handshake.

Parameters:
MAX_PREFIX, 4, max legacy prefixes accepted before a fault
MAX_LEN, 15, max legal instruction length in bytes

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
win_valid  in  1  fetch window valid
win_ready  out  1  window accepted this cycle
win_data  in  128  fetch window; byte k = win_data[8k+7:8k], byte 0 first
map_op0  out  8  first opcode byte to size map i0..i7 (i0 = bit 7)
map_op1  out  8  byte after first opcode byte to size map i8..i15 (i8 = bit 7)
map_opsize  in  1  size-map opsize flag
map_modrm  in  1  size-map ModRM-present flag
map_imm1  in  1  size-map immediate code bit 1
map_imm0  in  1  size-map immediate code bit 0
map_f16  in  1  size-map fixed 16-bit immediate flag
ins_valid  out  1  instruction descriptor valid
ins_ready  in  1  decode stage accepts descriptor
ins_len  out  4  total instruction length
ins_prefix_cnt  out  3  number of prefixes
ins_opsize_pfx  out  1  0x66 seen
ins_two_byte  out  1  0x0F escape
ins_opsize  out  1  registered map_opsize
ins_modrm_pos  out  4  byte index of ModRM (0 if none)
ins_imm_pos  out  4  byte index of immediate
ins_imm_len  out  3  immediate bytes (0,1,2,4)
ins_fault  out  1  prefix overflow or length > MAX_LEN

Behaviour:
- Reset: state IDLE, ptr=0. All ins_* outputs = 0. win_ready=0, map_op0/op1=0. Reset mid-operation discards the latched window.
- States: IDLE, PFX, OPC, MRM, LEN, OUT.
- IDLE:
  - win_ready=1 (combinational, IDLE only).
  - On win_valid, latch win_data, clear counters, go to PFX.
- PFX: examine byte[ptr].
  - Prefix set: 66, 67, F0, F2, F3, 2E, 36, 3E, 26, 64, 65.
  - If the byte is a prefix: cnt++, ptr++, set opsize_pfx if 66.
  - If it is a prefix and cnt==MAX_PREFIX: fault, go to LEN.
  - Otherwise go to OPC.
- OPC:
  - map_op0=byte[ptr], map_op1=byte[ptr+1]; map flags are sampled the same cycle (the map is combinational).
  - If byte[ptr]==0F: two_byte=1, map_op0=0F, map_op1=byte[ptr+1], oplen=2; otherwise oplen=1.
  - modrm_pos = ptr+oplen when map_modrm=1.
  - Go to MRM if map_modrm, else LEN.
- Immediate length:
  - map_f16=1 forces 2.
  - Otherwise {imm1,imm0}: 00→0, 01→1, 10→2, 11→4 (2 if opsize_pfx).
- MRM (one cycle): decode mod/rm.
  - mod=11 → no SIB, no disp.
  - mod=01 → disp 1; mod=10 → disp 4.
  - mod=00 and rm=101 → disp 4.
  - rm=100 and mod≠11 → SIB=1; SIB base=101 with mod=00 → disp 4.
- LEN:
  - len = prefixes + oplen + modrm + sib + disp + imm.
  - imm_pos = len - imm_len.
  - len > MAX_LEN → fault, ins_len=MAX_LEN.
- OUT:
  - ins_valid=1; all ins_* fields held stable until ins_ready.
  - On handshake go to IDLE. The next window can be accepted the following cycle.
- Latency: window accepted cycle 0 → ins_valid at cycle P+4+M (P = prefix count, M = 1 if ModRM).
- Fault case: ins_fault=1 and ins_len = bytes consumed so far. The descriptor is still emitted, with the same handshake.
- Bytes beyond index 15 read as 00. 4-bit arithmetic saturates at 15.

Optional Feature:
DECODE_LEN_PERF_EN
- With it: adds output ports perf_ins_cnt (32) and perf_stall_cnt (32).
  - perf_ins_cnt increments on each ins handshake.
  - perf_stall_cnt increments each cycle in OUT with ins_ready=0.
  - Both wrap modulo 2^32 and reset to 0.
- Without it: the ports and counters do not exist.

Test Plan:
- Window 90 …, map flags 0 → ins_valid at cycle 4, len=1, prefix_cnt=0, imm_len=0, fault=0.
- Window 66 05 34 12, map imm=11 → len=4, prefix_cnt=1, opsize_pfx=1, imm_pos=2, imm_len=2, valid at cycle 5.
- Window 8B 84 24 10 00 00 00, map_modrm=1 → SIB+disp32, len=7, modrm_pos=1, valid at cycle 5.
- Window 66×5 then 90, MAX_PREFIX=4 → ins_fault=1, prefix_cnt=4.
- 90 with ins_ready held low 3 cycles → ins_* stable, win_ready=0 throughout; IDLE entered after the handshake.
- Assert reset during PFX of 66 66 90 → all outputs 0 immediately; a fresh window 90 afterwards yields len=1.
